// File: rtl/edge_line_cache.sv
// Direct-mapped edge-weight cache in front of the shared BlockRam read port.
// Serves adjacency-matrix weights (from, to) with hit/miss statistics.
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_line_cache #(
    parameter int INDEX_WIDTH   = `DEFAULT_INDEX_WIDTH,
    parameter int VALUE_WIDTH   = `DEFAULT_VALUE_WIDTH,
    parameter int MADDR_WIDTH   = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH   = `DEFAULT_MDATA_WIDTH,
    parameter int CACHE_LINES   = 16,
    parameter int LINE_BITS     = 4,
    parameter int ELEMENT_BYTES = MADDR_WIDTH / 8,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   config_load,
    input  logic [MADDR_WIDTH-1:0] base_address,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   query_enable,
    input  logic [INDEX_WIDTH-1:0] from_node,
    input  logic [INDEX_WIDTH-1:0] to_node,
    input  logic                   invalidate,
    output logic                   ready,
    output logic [VALUE_WIDTH-1:0] edge_value,
    output logic                   out_of_range,
    inout  logic [MADDR_WIDTH-1:0] mem_addr,
    inout  logic [MDATA_WIDTH-1:0] mem_data,
    output logic                   mem_read_enable,
    input  logic                   mem_read_ready,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic [COUNT_WIDTH-1:0] miss_count,
    output logic [1:0]             debug_state
);
    // Query handshake: query_enable is a level request; ready stays high in DONE
    // for as long as query_enable holds and from/to match the captured key.
    localparam int FLAT_WIDTH = 2 * INDEX_WIDTH;
    localparam int TAG_WIDTH  = FLAT_WIDTH - LINE_BITS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOOKUP  = 2'd1;
    localparam logic [1:0] S_MEM_REQ = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             state;
    logic [MADDR_WIDTH-1:0] cfg_base;
    logic [INDEX_WIDTH-1:0] cfg_n;
    logic [INDEX_WIDTH-1:0] key_from;
    logic [INDEX_WIDTH-1:0] key_to;
    logic [CACHE_LINES-1:0] valid;
    logic                   inv_seen;
    logic [TAG_WIDTH-1:0]   tag_mem  [CACHE_LINES];
    logic [VALUE_WIDTH-1:0] data_mem [CACHE_LINES];

    logic [FLAT_WIDTH-1:0]  flat;
    logic [LINE_BITS-1:0]   line;
    logic [TAG_WIDTH-1:0]   tag;
    logic [MADDR_WIDTH-1:0] addr_calc;
    logic                   key_oor;
    logic                   lookup_hit;
    logic                   key_changed;
    logic [VALUE_WIDTH-1:0] fill_value;
    logic                   unused_mem_bits;

    assign flat        = FLAT_WIDTH'(key_from) * FLAT_WIDTH'(cfg_n) + FLAT_WIDTH'(key_to);
    assign line        = flat[LINE_BITS-1:0];
    assign tag         = flat[FLAT_WIDTH-1:LINE_BITS];
    assign addr_calc   = cfg_base + MADDR_WIDTH'(flat) * MADDR_WIDTH'(ELEMENT_BYTES);
    assign key_oor     = (key_from >= cfg_n) || (key_to >= cfg_n);
    assign lookup_hit  = valid[line] && (tag_mem[line] == tag) && !invalidate;
    assign key_changed = (from_node != key_from) || (to_node != key_to);
    assign fill_value  = mem_data[VALUE_WIDTH-1:0];
    assign unused_mem_bits = ^mem_data[MDATA_WIDTH-1:VALUE_WIDTH];

    assign ready           = (state == S_DONE);
    assign mem_read_enable = (state == S_MEM_REQ);
    assign mem_addr        = mem_read_enable ? addr_calc : {MADDR_WIDTH{1'bz}};
    assign debug_state     = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cfg_base     <= '0;
            cfg_n        <= '0;
            key_from     <= '0;
            key_to       <= '0;
            valid        <= '0;
            inv_seen     <= 1'b0;
            edge_value   <= '0;
            out_of_range <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            if (invalidate) valid <= '0;
            case (state)
                S_IDLE: begin
                    if (config_load) begin
                        cfg_base   <= base_address;
                        cfg_n      <= number_of_nodes;
                        valid      <= '0;
                        hit_count  <= '0;
                        miss_count <= '0;
                    end else if (query_enable) begin
                        key_from <= from_node;
                        key_to   <= to_node;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (key_oor) begin
                        edge_value   <= '1;
                        out_of_range <= 1'b1;
                        state        <= S_DONE;
                    end else if (lookup_hit) begin
                        edge_value <= data_mem[line];
                        if (hit_count != '1) hit_count <= hit_count + COUNT_WIDTH'(1);
                        state <= S_DONE;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + COUNT_WIDTH'(1);
                        inv_seen <= 1'b0;
                        state    <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (invalidate) inv_seen <= 1'b1;
                    if (mem_read_ready) begin
                        edge_value <= fill_value;
                        // An invalidate seen at any point of the fill leaves the line invalid.
                        if (!inv_seen && !invalidate) valid[line] <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (!query_enable) begin
                        out_of_range <= 1'b0;
                        state        <= S_IDLE;
                    end else if (key_changed) begin
                        key_from     <= from_node;
                        key_to       <= to_node;
                        out_of_range <= 1'b0;
                        state        <= S_LOOKUP;
                    end
                end
            endcase
        end
    end

    // Tag/data arrays need no reset: the valid bits guard them.
    always_ff @(posedge clock) begin
        if (state == S_MEM_REQ && mem_read_ready) begin
            tag_mem[line]  <= tag;
            data_mem[line] <= fill_value;
        end
    end

endmodule

// File: doc/edge_line_cache.md
Name: edge_line_cache

Overview:
- Parametrised successor to the single-entry edge fetcher. Serves adjacency-matrix edge weights (from_node, to_node) to the Dijkstra datapath.
- Uses a direct-mapped cache of CACHE_LINES entries in front of the shared BlockRam read interface.
- Adds hit/miss counters, bulk invalidate, out-of-range detection and a runtime config-load strobe.

Parameters:
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, node index width.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, edge weight width.
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width (>= VALUE_WIDTH).
- CACHE_LINES, 16, line count; power of two, >= 2.
- LINE_BITS, 4, log2(CACHE_LINES).
- ELEMENT_BYTES, MADDR_WIDTH/8, byte stride between matrix elements.
- COUNT_WIDTH, 16, hit/miss counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- config_load  in  1  capture base_address/number_of_nodes; honoured in IDLE only.
- base_address  in  MADDR_WIDTH  matrix base byte address.
- number_of_nodes  in  INDEX_WIDTH  matrix dimension N.
- query_enable  in  1  query request, level.
- from_node  in  INDEX_WIDTH  row.
- to_node  in  INDEX_WIDTH  column.
- invalidate  in  1  clear all valid bits.
- ready  out  1  edge_value valid for current key.
- edge_value  out  VALUE_WIDTH  returned weight.
- out_of_range  out  1  qualifies ready: index >= N.
- mem_addr  inout  MADDR_WIDTH  driven only while mem_read_enable=1, else Z.
- mem_data  inout  MDATA_WIDTH  never driven by this block.
- mem_read_enable  out  1  memory read request.
- mem_read_ready  in  1  memory data valid.
- hit_count  out  COUNT_WIDTH  saturating hits.
- miss_count  out  COUNT_WIDTH  saturating misses.

Behaviour:
- Reset (reset=0, async) forces:
  - state IDLE; ready=0, out_of_range=0, edge_value=0, mem_read_enable=0, mem_addr=Z.
  - All valid bits clear; counters 0; base 0; N 0.
  - Mid-fill reset abandons the request immediately.
- Config:
  - config_load in IDLE latches base and N, clears all valid bits and both counters; takes priority over query_enable that cycle.
  - config_load ignored in other states.
  - Block uses only latched config; live base_address/number_of_nodes ignored otherwise.
- Addressing:
  - flat = from*N + to, width 2*INDEX_WIDTH.
  - addr = base + flat*ELEMENT_BYTES, truncated modulo 2^MADDR_WIDTH.
  - line = flat[LINE_BITS-1:0]; tag = remaining upper flat bits.
- FSM: IDLE, LOOKUP, MEM_REQ, DONE.
  - IDLE: query_enable=1 -> capture key (from,to), go LOOKUP.
  - LOOKUP, key out of range (from>=N or to>=N): edge_value all ones, out_of_range=1, no memory access, no counter change -> DONE.
  - LOOKUP, hit (valid && tag match && no invalidate this cycle): edge_value=line data, hit_count++ -> DONE.
  - LOOKUP, otherwise: miss_count++ -> MEM_REQ.
  - MEM_REQ: mem_read_enable=1 and mem_addr=addr, held until mem_read_ready=1 at a rising edge. Then line data = mem_data[VALUE_WIDTH-1:0], tag written, valid=1, edge_value loaded -> DONE.
  - DONE: ready=1. Stays while query_enable=1 and from/to equal captured key.
  - DONE, query_enable=0 -> IDLE.
  - DONE, key differs -> recapture key, LOOKUP; ready low next cycle.
- Latency from query accepted in IDLE:
  - Hit or out-of-range: ready at 2nd edge.
  - Miss: ready 1 edge after mem_read_ready sampled.
- Outputs hold:
  - edge_value holds until the next completed lookup.
  - out_of_range clears when leaving DONE.
- Invalidate:
  - Clears all valid bits in one cycle, any state.
  - Asserted during MEM_REQ: data still returned, but the line is left invalid.
- Counters saturate at all ones; no wrap.

Test Plan:
- Init RAM word at 64+(r*4+c)*ELEMENT_BYTES to r*c for r,c in 0..3. config_load base=64, N=4. Then change inputs to base=87, N=105. Query all 16 pairs -> edge_value=r*c each; miss_count=16, hit_count=0.
- Repeat the same 16 queries -> every ready 2 edges after query; mem_read_enable stays 0; hit_count=16.
- Query (3,3), then (0,0) with CACHE_LINES=4 (flat 15 and 0 share line 3? no: 15->3, 0->0; use (0,3) and (3,3): lines 3,3) -> second is a miss and evicts the first; re-query (0,3) -> miss, value 0.
- Query (4,1) with N=4 -> ready, out_of_range=1, edge_value all ones, no memory read, counters unchanged.
- Pulse invalidate, then re-query (2,3) -> miss, value 6. Pulse invalidate mid-MEM_REQ -> value 6 returned, the next (2,3) query still misses.
- Assert reset mid-MEM_REQ -> mem_read_enable=0 and mem_addr=Z immediately; counters 0; post-reset query of (1,2) misses and returns 2.
